// File: rtl/core_pkg.sv
// Shared RV32I control types: FSM states, datapath select encodings, opcodes.
// Pure declarations; used by the sequencer, its decoder and the immediate generator.
package core_pkg;

   typedef enum logic [3:0] {
      IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_ALU    = 2'd1,
      PC_BRANCH = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_e;

   typedef enum logic {ALU_A_RS1 = 1'b0, ALU_A_PC  = 1'b1} alu_a_e;
   typedef enum logic {ALU_B_RS2 = 1'b0, ALU_B_IMM = 1'b1} alu_b_e;

   typedef enum logic [3:0] {
      CLS_ILLEGAL, CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE
   } instr_cls_e;

   localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
   localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
   localparam logic [4:0] OPCODE_STORE    = 5'b01000;
   localparam logic [4:0] OPCODE_OP       = 5'b01100;
   localparam logic [4:0] OPCODE_LUI      = 5'b01101;
   localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
   localparam logic [4:0] OPCODE_JALR     = 5'b11001;
   localparam logic [4:0] OPCODE_JAL      = 5'b11011;
   localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

   typedef struct packed {
      instr_cls_e cls;
      alu_a_e     a_sel;
      alu_b_e     b_sel;
      wb_sel_e    wb_sel;
      logic       jump;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus static ALU/writeback selects.
// Zero latency; no handshake.
module ctrl_decode
   import core_pkg::*;
(
   input  logic [6:0] opcode,
   output dec_t       dec
);

   always_comb begin
      dec = '{cls: CLS_ILLEGAL, a_sel: ALU_A_RS1, b_sel: ALU_B_RS2, wb_sel: WB_ALU, jump: 1'b0};
      // Compressed/reserved encodings and SYSTEM stay illegal.
      if (opcode[1:0] == 2'b11) begin
         case (opcode[6:2])
            OPCODE_OP:       dec.cls = CLS_OP;
            OPCODE_OP_IMM: begin
               dec.cls   = CLS_OP_IMM;
               dec.b_sel = ALU_B_IMM;
            end
            OPCODE_LOAD: begin
               dec.cls    = CLS_LOAD;
               dec.b_sel  = ALU_B_IMM;
               dec.wb_sel = WB_LOAD;
            end
            OPCODE_STORE: begin
               dec.cls   = CLS_STORE;
               dec.b_sel = ALU_B_IMM;
            end
            OPCODE_JALR: begin
               dec.cls    = CLS_JALR;
               dec.b_sel  = ALU_B_IMM;
               dec.wb_sel = WB_PC4;
               dec.jump   = 1'b1;
            end
            OPCODE_AUIPC: begin
               dec.cls   = CLS_AUIPC;
               dec.a_sel = ALU_A_PC;
               dec.b_sel = ALU_B_IMM;
            end
            OPCODE_JAL: begin
               dec.cls    = CLS_JAL;
               dec.a_sel  = ALU_A_PC;
               dec.b_sel  = ALU_B_IMM;
               dec.wb_sel = WB_PC4;
               dec.jump   = 1'b1;
            end
            OPCODE_LUI: begin
               dec.cls    = CLS_LUI;
               dec.wb_sel = WB_IMM;
            end
            OPCODE_BRANCH:   dec.cls = CLS_BRANCH;
            OPCODE_MISC_MEM: dec.cls = CLS_FENCE;
            default:         dec.cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer driving the shared datapath; 3-7 cycles per instruction.
// Stalls in request states until mem_gnt_i and in wait states until mem_rvalid_i.
module multicycle_ctrl
   import core_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [31:0]          instr_i,
   input  logic                 branch_taken_i,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic                 mem_addr_sel_o,
   output logic                 ir_we_o,
   output logic                 pc_we_o,
   output logic [1:0]           pc_sel_o,
   output logic                 alu_a_sel_o,
   output logic                 alu_b_sel_o,
   output logic                 rf_we_o,
   output logic [1:0]           wb_sel_o,
   output logic                 illegal_o,
   output logic [INSTRET_W-1:0] instret_o
);

   state_e  st, nxt;
   dec_t    dec;
   pc_sel_e pc_sel;
   logic    is_load, is_store;
   logic    unused_instr;

   ctrl_decode u_decode (
      .opcode (instr_i[6:0]),
      .dec    (dec)
   );

   assign is_load      = (dec.cls == CLS_LOAD);
   assign is_store     = (dec.cls == CLS_STORE);
   assign unused_instr = ^instr_i[31:7];

   always_comb begin
      nxt = st;
      case (st)
         IDLE:       nxt = FETCH_REQ;
         FETCH_REQ:  if (mem_gnt_i) nxt = FETCH_WAIT;
         FETCH_WAIT: if (mem_rvalid_i) nxt = DECODE;
         DECODE: begin
            if (dec.cls == CLS_ILLEGAL)    nxt = TRAP;
            else if (dec.cls == CLS_FENCE) nxt = FETCH_REQ;
            else                           nxt = EXEC;
         end
         EXEC: begin
            if (dec.cls == CLS_BRANCH)     nxt = FETCH_REQ;
            else if (is_load || is_store)  nxt = MEM_REQ;
            else                           nxt = WB;
         end
         MEM_REQ:    if (mem_gnt_i) nxt = is_store ? FETCH_REQ : MEM_WAIT;
         MEM_WAIT:   if (mem_rvalid_i) nxt = WB;
         WB:         nxt = FETCH_REQ;
         TRAP:       nxt = TRAP;
         default:    nxt = IDLE;
      endcase
   end

   // Handshake- and comparator-qualified strobes; everything else is registered Moore.
   assign ir_we_o = (st == FETCH_WAIT) && mem_rvalid_i;

   always_comb begin
      pc_we_o = 1'b0;
      pc_sel  = PC_PLUS4;
      case (st)
         DECODE:  pc_we_o = (dec.cls == CLS_FENCE);
         EXEC: begin
            if (dec.cls == CLS_BRANCH) begin
               pc_we_o = 1'b1;
               pc_sel  = branch_taken_i ? PC_BRANCH : PC_PLUS4;
            end
         end
         MEM_REQ: pc_we_o = is_store && mem_gnt_i;
         WB: begin
            pc_we_o = 1'b1;
            if (dec.jump) pc_sel = PC_ALU;
         end
         default: ;
      endcase
   end

   assign pc_sel_o = pc_sel;

   // Moore outputs are loaded with the values of the state being entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st             <= IDLE;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_sel_o <= 1'b0;
         alu_a_sel_o    <= 1'b0;
         alu_b_sel_o    <= 1'b0;
         rf_we_o        <= 1'b0;
         wb_sel_o       <= 2'd0;
         illegal_o      <= 1'b0;
         instret_o      <= '0;
      end else begin
         st             <= nxt;
         mem_req_o      <= (nxt == FETCH_REQ) || (nxt == MEM_REQ);
         mem_we_o       <= (nxt == MEM_REQ) && is_store;
         mem_addr_sel_o <= (nxt == MEM_REQ);
         alu_a_sel_o    <= (nxt == EXEC || nxt == MEM_REQ) ? dec.a_sel : ALU_A_RS1;
         alu_b_sel_o    <= (nxt == EXEC || nxt == MEM_REQ) ? dec.b_sel : ALU_B_RS2;
         rf_we_o        <= (nxt == WB);
         wb_sel_o       <= (nxt == WB) ? dec.wb_sel : WB_ALU;
         illegal_o      <= (nxt == TRAP);
         if (pc_we_o) instret_o <= instret_o + INSTRET_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle-by-cycle output vectors.
// Small INSTRET_W so counter wrap is reachable in a few FENCEs.
module tb_multicycle_ctrl;

   localparam int IW = 3;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00000463;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_FENCE = 32'h0000000F;
   localparam logic [31:0] I_ECALL = 32'h00000073;

   // {req, we, addr_sel, ir_we, pc_we, pc_sel[1:0], a, b, rf_we, wb_sel[1:0], illegal}
   localparam logic [12:0] O_ZERO     = 13'b0_0_0_0_0_00_0_0_0_00_0;
   localparam logic [12:0] O_FREQ     = 13'b1_0_0_0_0_00_0_0_0_00_0;
   localparam logic [12:0] O_FWAIT_RV = 13'b0_0_0_1_0_00_0_0_0_00_0;
   localparam logic [12:0] O_FENCE    = 13'b0_0_0_0_1_00_0_0_0_00_0;
   localparam logic [12:0] O_EX_IMM   = 13'b0_0_0_0_0_00_0_1_0_00_0;
   localparam logic [12:0] O_WB_ALU   = 13'b0_0_0_0_1_00_0_0_1_00_0;
   localparam logic [12:0] O_LD_REQ   = 13'b1_0_1_0_0_00_0_1_0_00_0;
   localparam logic [12:0] O_WB_LD    = 13'b0_0_0_0_1_00_0_0_1_01_0;
   localparam logic [12:0] O_ST_REQ   = 13'b1_1_1_0_0_00_0_1_0_00_0;
   localparam logic [12:0] O_ST_GNT   = 13'b1_1_1_0_1_00_0_1_0_00_0;
   localparam logic [12:0] O_BR_T     = 13'b0_0_0_0_1_10_0_0_0_00_0;
   localparam logic [12:0] O_BR_N     = 13'b0_0_0_0_1_00_0_0_0_00_0;
   localparam logic [12:0] O_EX_JAL   = 13'b0_0_0_0_0_00_1_1_0_00_0;
   localparam logic [12:0] O_WB_JAL   = 13'b0_0_0_0_1_01_0_0_1_10_0;
   localparam logic [12:0] O_TRAP     = 13'b0_0_0_0_0_00_0_0_0_00_1;

   logic          clk_i, rst_ni;
   logic [31:0]   instr_i;
   logic          branch_taken_i, mem_gnt_i, mem_rvalid_i;
   logic          mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o;
   logic [1:0]    pc_sel_o, wb_sel_o;
   logic          alu_a_sel_o, alu_b_sel_o, rf_we_o, illegal_o;
   logic [IW-1:0] instret_o;
   logic [12:0]   outs;

   logic [31:0]   fetch_word;
   int            exp_ret;
   int            passed, total;

   multicycle_ctrl #(.INSTRET_W(IW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_i        (instr_i),
      .branch_taken_i (branch_taken_i),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_sel_o (mem_addr_sel_o),
      .ir_we_o        (ir_we_o),
      .pc_we_o        (pc_we_o),
      .pc_sel_o       (pc_sel_o),
      .alu_a_sel_o    (alu_a_sel_o),
      .alu_b_sel_o    (alu_b_sel_o),
      .rf_we_o        (rf_we_o),
      .wb_sel_o       (wb_sel_o),
      .illegal_o      (illegal_o),
      .instret_o      (instret_o)
   );

   assign outs = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_sel_o,
                  alu_a_sel_o, alu_b_sel_o, rf_we_o, wb_sel_o, illegal_o};

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // One clock of stimulus; the IR loads fetch_word after a cycle with ir_we high.
   task automatic drive(input logic g, input logic r);
      logic ld;
      ld = ir_we_o;
      @(posedge clk_i);
      #1;
      if (ld) instr_i = fetch_word;
      mem_gnt_i    = g;
      mem_rvalid_i = r;
      #3;
   endtask

   task automatic fetch_zw(input logic [31:0] w);
      fetch_word = w;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; branch_taken_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni  = 1'b1;
      exp_ret = 0;
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; instr_i = 32'h0; fetch_word = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; branch_taken_i = 1'b0;
      #2;
      repeat (2) @(posedge clk_i);
      #1;
      total++; if (outs !== O_ZERO) $display("FAIL reset_outs got %b want %b", outs, O_ZERO); else passed++;
      total++; if (instret_o !== IW'(0)) $display("FAIL reset_instret got %0d want 0", instret_o); else passed++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_ret = 0;
      #1;
      total++; if (outs !== O_ZERO) $display("FAIL idle_outs got %b want %b", outs, O_ZERO); else passed++;
   endtask

   task automatic test_addi();
      fetch_word = I_ADDI;
      drive(1'b1, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL addi_freq got %b want %b", outs, O_FREQ); else passed++;
      drive(1'b0, 1'b1);
      total++; if (outs !== O_FWAIT_RV) $display("FAIL addi_fwait got %b want %b", outs, O_FWAIT_RV); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_ZERO) $display("FAIL addi_decode got %b want %b", outs, O_ZERO); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_EX_IMM) $display("FAIL addi_exec got %b want %b", outs, O_EX_IMM); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_WB_ALU) $display("FAIL addi_wb got %b want %b", outs, O_WB_ALU); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL addi_instret_pre got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
      exp_ret++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL addi_next got %b want %b", outs, O_FREQ); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL addi_instret got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
   endtask

   task automatic test_load();
      fetch_zw(I_LW);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      total++; if (outs !== O_EX_IMM) $display("FAIL lw_exec got %b want %b", outs, O_EX_IMM); else passed++;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0);
         total++; if (outs !== O_LD_REQ) $display("FAIL lw_mreq_stall%0d got %b want %b", i, outs, O_LD_REQ); else passed++;
      end
      drive(1'b1, 1'b0);
      total++; if (outs !== O_LD_REQ) $display("FAIL lw_mreq_gnt got %b want %b", outs, O_LD_REQ); else passed++;
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      total++; if (outs !== O_ZERO) $display("FAIL lw_mwait got %b want %b", outs, O_ZERO); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL lw_instret_pre got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_WB_LD) $display("FAIL lw_wb got %b want %b", outs, O_WB_LD); else passed++;
      exp_ret++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL lw_next got %b want %b", outs, O_FREQ); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL lw_instret got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
   endtask

   task automatic test_store();
      fetch_word = I_SW;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL sw_freq_stall got %b want %b", outs, O_FREQ); else passed++;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      total++; if (outs !== O_FWAIT_RV) $display("FAIL sw_fwait got %b want %b", outs, O_FWAIT_RV); else passed++;
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      total++; if (outs !== O_EX_IMM) $display("FAIL sw_exec got %b want %b", outs, O_EX_IMM); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_ST_REQ) $display("FAIL sw_mreq_stall got %b want %b", outs, O_ST_REQ); else passed++;
      drive(1'b1, 1'b0);
      total++; if (outs !== O_ST_GNT) $display("FAIL sw_mreq_gnt got %b want %b", outs, O_ST_GNT); else passed++;
      exp_ret++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL sw_next got %b want %b", outs, O_FREQ); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL sw_instret got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
   endtask

   task automatic test_branch(input logic taken);
      logic [12:0] want;
      want = taken ? O_BR_T : O_BR_N;
      branch_taken_i = taken;
      fetch_zw(I_BEQ);
      drive(1'b0, 1'b0);
      total++; if (outs !== O_ZERO) $display("FAIL beq%0b_decode got %b want %b", taken, outs, O_ZERO); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== want) $display("FAIL beq%0b_exec got %b want %b", taken, outs, want); else passed++;
      exp_ret++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL beq%0b_next got %b want %b", taken, outs, O_FREQ); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL beq%0b_instret got %0d want %0d", taken, instret_o, IW'(exp_ret)); else passed++;
      branch_taken_i = 1'b0;
   endtask

   task automatic test_jal();
      fetch_zw(I_JAL);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      total++; if (outs !== O_EX_JAL) $display("FAIL jal_exec got %b want %b", outs, O_EX_JAL); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_WB_JAL) $display("FAIL jal_wb got %b want %b", outs, O_WB_JAL); else passed++;
      exp_ret++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL jal_next got %b want %b", outs, O_FREQ); else passed++;
   endtask

   task automatic test_fence_wrap();
      for (int i = 0; i < 8; i++) begin
         fetch_zw(I_FENCE);
         drive(1'b0, 1'b0);
         total++; if (outs !== O_FENCE) $display("FAIL fence%0d_decode got %b want %b", i, outs, O_FENCE); else passed++;
         total++; if (instret_o !== IW'(exp_ret)) $display("FAIL fence%0d_instret got %0d want %0d", i, instret_o, IW'(exp_ret)); else passed++;
         exp_ret++;
      end
      drive(1'b0, 1'b0);
      total++; if (outs !== O_FREQ) $display("FAIL fence_next got %b want %b", outs, O_FREQ); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL fence_wrap got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
   endtask

   task automatic test_illegal();
      fetch_zw(32'h0);
      drive(1'b0, 1'b0);
      total++; if (outs !== O_ZERO) $display("FAIL ill0_decode got %b want %b", outs, O_ZERO); else passed++;
      drive(1'b1, 1'b0);
      total++; if (outs !== O_TRAP) $display("FAIL ill0_trap1 got %b want %b", outs, O_TRAP); else passed++;
      drive(1'b0, 1'b1);
      total++; if (outs !== O_TRAP) $display("FAIL ill0_trap2 got %b want %b", outs, O_TRAP); else passed++;
      drive(1'b0, 1'b0);
      total++; if (outs !== O_TRAP) $display("FAIL ill0_trap3 got %b want %b", outs, O_TRAP); else passed++;
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL ill0_instret got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
      apply_reset();
      fetch_zw(I_ECALL);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      total++; if (outs !== O_TRAP) $display("FAIL ecall_trap got %b want %b", outs, O_TRAP); else passed++;
      total++; if (instret_o !== IW'(0)) $display("FAIL ecall_instret got %0d want 0", instret_o); else passed++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      fetch_zw(I_ADDI);
      repeat (3) drive(1'b0, 1'b0);
      exp_ret++;
      fetch_zw(I_LW);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      total++; if (instret_o !== IW'(exp_ret)) $display("FAIL rstmid_pre got %0d want %0d", instret_o, IW'(exp_ret)); else passed++;
      #1;
      rst_ni = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      total++; if (outs !== O_ZERO) $display("FAIL rstmid_outs got %b want %b", outs, O_ZERO); else passed++;
      total++; if (instret_o !== IW'(0)) $display("FAIL rstmid_instret got %0d want 0", instret_o); else passed++;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni  = 1'b1;
      exp_ret = 0;
      #1;
      drive(1'b0, 1'b1);
      total++; if (outs !== O_FREQ) $display("FAIL rstmid_freq got %b want %b", outs, O_FREQ); else passed++;
      drive(1'b0, 1'b1);
      total++; if (outs !== O_FREQ) $display("FAIL rstmid_rvalid_ignored got %b want %b", outs, O_FREQ); else passed++;
      fetch_zw(I_ADDI);
      total++; if (outs !== O_FWAIT_RV) $display("FAIL rstmid_refetch got %b want %b", outs, O_FWAIT_RV); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_addi();
      test_load();
      test_store();
      test_branch(1'b1);
      test_branch(1'b0);
      test_jal();
      test_fence_wrap();
      test_illegal();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables and select lines of the shared datapath. That datapath is the PC, IR, register file, ALU, immediate generator and one unified memory port. Memory uses a req/gnt/rvalid handshake with at most one transaction outstanding. The block also counts retired instructions and halts on illegal encodings.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_i  in  32  current IR contents
branch_taken_i  in  1  branch comparator result, valid in EXEC
mem_gnt_i  in  1  memory accepted the request this cycle
mem_rvalid_i  in  1  read data valid this cycle
mem_req_o  out  1  memory request
mem_we_o  out  1  store request
mem_addr_sel_o  out  1  0 = PC (fetch), 1 = ALU result (data)
ir_we_o  out  1  IR load enable
pc_we_o  out  1  PC load enable
pc_sel_o  out  2  0 = PC+4, 1 = ALU result, 2 = branch target
alu_a_sel_o  out  1  0 = rs1, 1 = PC
alu_b_sel_o  out  1  0 = rs2, 1 = immediate
rf_we_o  out  1  register-file write enable
wb_sel_o  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate
illegal_o  out  1  sticky illegal-instruction flag
instret_o  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset: state IDLE; all outputs 0; instret_o = 0; illegal_o = 0. Reset mid-transaction abandons it immediately; a pending rvalid after reset is ignored.
- Opcode is instr_i[6:2]. instr_i[1:0] != 2'b11 is illegal.
- Outputs are Moore per state except the gnt/rvalid-qualified strobes listed below.
- IDLE -> FETCH_REQ unconditionally. All outputs 0.
- FETCH_REQ:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_sel_o = 0.
  - Hold the request until mem_gnt_i, then go to FETCH_WAIT.
- FETCH_WAIT:
  - Wait for mem_rvalid_i. ir_we_o = mem_rvalid_i (Mealy), then go to DECODE.
  - rvalid in the same cycle as gnt is not legal; the earliest rvalid is the cycle after gnt.
- DECODE: one cycle.
  - Unknown opcode, bad [1:0], or SYSTEM -> TRAP.
  - MISC_MEM (FENCE) is a NOP: pc_we_o = 1, pc_sel_o = 0, retire, go to FETCH_REQ.
  - Otherwise go to EXEC.
- EXEC, by opcode:
  - OP: a = rs1, b = rs2.
  - OP_IMM, LOAD, STORE, JALR: a = rs1, b = imm.
  - AUIPC, JAL: a = PC, b = imm.
  - LUI: no ALU use.
  - BRANCH: alu_a_sel_o = 0, alu_b_sel_o = 0 (comparator). Drive pc_we_o = 1 and pc_sel_o = branch_taken_i ? 2 : 0. Retire, go to FETCH_REQ.
  - LOAD/STORE go to MEM_REQ; all others go to WB.
- MEM_REQ:
  - mem_req_o = 1, mem_addr_sel_o = 1, mem_we_o = 1 for STORE. Operand selects are held from EXEC.
  - On gnt, STORE: pc_we_o = 1, pc_sel_o = 0 (Mealy), retire, go to FETCH_REQ.
  - On gnt, LOAD: go to MEM_WAIT.
- MEM_WAIT: wait for mem_rvalid_i, then go to WB.
- WB: single cycle. rf_we_o = 1, pc_we_o = 1, retire, go to FETCH_REQ.
  - wb_sel_o: OP/OP_IMM/AUIPC = 0, LOAD = 1, JAL/JALR = 2, LUI = 3.
  - pc_sel_o: JAL/JALR = 1; otherwise 0.
  - The datapath clears the JALR target LSB.
- TRAP: illegal_o = 1. All enables and requests are 0. Absorbing until reset.
- Retire = cycle with pc_we_o = 1: instret_o increments by exactly 1 per retire, and wraps.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 5 cycles.
  - BRANCH: 4 cycles.
  - FENCE: 3 cycles.
  - STORE: 5 cycles.
  - LOAD: 7 cycles.

Decomposition:
- Shared package core_pkg holds:
  - the state enum (IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP);
  - the pc_sel, wb_sel and alu-source enums;
  - the existing 5-bit OPCODE_* constants (shared with immgen).
- One sub-module is natural: ctrl_decode, combinational, mapping opcode to an instruction class plus static selects. The FSM and counter stay in multicycle_ctrl.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), zero-wait memory -> req high 1 cycle, ir_we cycle 3, EXEC a/b = 0/1, WB rf_we = 1 wb_sel = 0 pc_sel = 0; instret 0 -> 1 after 5 cycles.
2. LW x2,0(x1) (0x0000A103), gnt after 2 stall cycles, rvalid 3 cycles later -> mem_req/addr_sel = 1, we = 0 held through stalls; WB wb_sel = 1; exactly one retire.
3. SW x2,4(x1) (0x0020A223) -> mem_we = 1 with req until gnt; pc_we in the gnt cycle; rf_we never asserted.
4. BEQ x0,x0,8 (0x00000463) with branch_taken = 1, then repeat with 0 -> pc_sel 2 then 0, pc_we in EXEC, 4 cycles each, no rf_we.
5. JAL x1,16 (0x010000EF) -> EXEC a/b = 1/1; WB wb_sel = 2, pc_sel = 1, rf_we = 1.
6. Fetch 0x00000000, then 0x00000073 after reset -> TRAP, illegal_o stays 1 with no req; rst_ni low mid-MEM_WAIT -> all outputs 0 immediately, instret = 0, late rvalid ignored.
